// File: rtl/blink_monitor.sv
// blink_monitor
//   Receive-side checker for the board LED blink pattern. The asynchronous
//   blink input is brought into clk_i through a two-flop synchronizer. Each
//   high width and each rising-to-rising period is measured in clk_i cycles.
//   Every complete period is then checked against the nominal high width and
//   the nominal period, each with a +/- TOL window.
//
// Ports
//   clk_i         in   1      system clock, rising edge
//   rst_ni        in   1      asynchronous reset, active low
//   blink_i       in   1      blink signal, asynchronous to clk_i
//   high_cnt_o    out  CNT_W  last measured high width, cycles
//   period_cnt_o  out  CNT_W  last measured period, cycles
//   meas_valid_o  out  1      one-cycle strobe with each new result
//   high_ok_o     out  1      last high width within T_HIGH_NOM +/- TOL
//   period_ok_o   out  1      last period within T_PERIOD_NOM +/- TOL
//   timeout_o     out  1      sticky: expected edge missing for T_TIMEOUT cycles
//
// States
//   WAIT_RISE | idle after reset or timeout; waits for a rise, no result at that rise
//   HIGH      | blink is high, counting the high width
//   LOW       | blink is low, counting the rest of the period

module blink_monitor #(
    parameter int CLK_FREQ     = 125_000_000,
    parameter int T_HIGH_NOM   = (CLK_FREQ + 9) / 10,
    parameter int T_PERIOD_NOM = CLK_FREQ,
    parameter int TOL          = CLK_FREQ / 1000,
    parameter int T_TIMEOUT    = 2 * T_PERIOD_NOM,
    parameter int CNT_W        = 28
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             blink_i,
    output logic [CNT_W-1:0] high_cnt_o,
    output logic [CNT_W-1:0] period_cnt_o,
    output logic             meas_valid_o,
    output logic             high_ok_o,
    output logic             period_ok_o,
    output logic             timeout_o
);

    // Window limits are precomputed so the checks never rely on a
    // wrapping subtraction of the measured value.
    localparam logic [CNT_W-1:0] HIGH_MIN   = CNT_W'(T_HIGH_NOM - TOL);
    localparam logic [CNT_W-1:0] HIGH_MAX   = CNT_W'(T_HIGH_NOM + TOL);
    localparam logic [CNT_W-1:0] PERIOD_MIN = CNT_W'(T_PERIOD_NOM - TOL);
    localparam logic [CNT_W-1:0] PERIOD_MAX = CNT_W'(T_PERIOD_NOM + TOL);
    localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(T_TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);

    typedef enum logic [1:0] {
        WAIT_RISE = 2'd0,
        HIGH      = 2'd1,
        LOW       = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic             s1, s2, prev;
    logic             rise, fall;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] high_w, high_w_nxt;
    logic [CNT_W-1:0] high_cnt_nxt, period_cnt_nxt;
    logic             meas_valid_nxt, high_ok_nxt, period_ok_nxt, timeout_nxt;
    logic             cnt_at_timeout;

    // The synchronizer delay is the same for both edges, so measured
    // widths match the input widths exactly.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= blink_i;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign rise           = s2 & ~prev;
    assign fall           = ~s2 & prev;
    assign cnt_at_timeout = (cnt == TIMEOUT_C);

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        high_w_nxt     = high_w;
        high_cnt_nxt   = high_cnt_o;
        period_cnt_nxt = period_cnt_o;
        meas_valid_nxt = 1'b0;
        high_ok_nxt    = high_ok_o;
        period_ok_nxt  = period_ok_o;
        timeout_nxt    = timeout_o;

        case (state)
            WAIT_RISE: begin
                // A fall here is the tail of a pulse whose rise was not seen.
                if (rise) begin
                    state_nxt   = HIGH;
                    cnt_nxt     = ONE_C;
                    timeout_nxt = 1'b0;
                end
            end

            HIGH: begin
                cnt_nxt = cnt + ONE_C;
                if (fall) begin
                    state_nxt  = LOW;
                    high_w_nxt = cnt;
                end else if (cnt_at_timeout) begin
                    state_nxt   = WAIT_RISE;
                    timeout_nxt = 1'b1;
                end
            end

            LOW: begin
                cnt_nxt = cnt + ONE_C;
                // An edge coinciding with the timeout count takes priority.
                if (rise) begin
                    state_nxt      = HIGH;
                    cnt_nxt        = ONE_C;
                    high_cnt_nxt   = high_w;
                    period_cnt_nxt = cnt;
                    meas_valid_nxt = 1'b1;
                    high_ok_nxt    = (high_w >= HIGH_MIN) && (high_w <= HIGH_MAX);
                    period_ok_nxt  = (cnt >= PERIOD_MIN) && (cnt <= PERIOD_MAX);
                end else if (cnt_at_timeout) begin
                    state_nxt   = WAIT_RISE;
                    timeout_nxt = 1'b1;
                end
            end

            default: begin
                state_nxt = WAIT_RISE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= WAIT_RISE;
            cnt          <= '0;
            high_w       <= '0;
            high_cnt_o   <= '0;
            period_cnt_o <= '0;
            meas_valid_o <= 1'b0;
            high_ok_o    <= 1'b0;
            period_ok_o  <= 1'b0;
            timeout_o    <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            high_w       <= high_w_nxt;
            high_cnt_o   <= high_cnt_nxt;
            period_cnt_o <= period_cnt_nxt;
            meas_valid_o <= meas_valid_nxt;
            high_ok_o    <= high_ok_nxt;
            period_ok_o  <= period_ok_nxt;
            timeout_o    <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_blink_monitor.sv
module tb_blink_monitor;

    localparam int CLK_FREQ     = 1000;
    localparam int T_HIGH_NOM   = 100;
    localparam int T_PERIOD_NOM = 1000;
    localparam int TOL          = 2;
    localparam int T_TIMEOUT    = 2000;
    localparam int CNT_W        = 12;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             blink_i;
    logic [CNT_W-1:0] high_cnt_o;
    logic [CNT_W-1:0] period_cnt_o;
    logic             meas_valid_o;
    logic             high_ok_o;
    logic             period_ok_o;
    logic             timeout_o;

    blink_monitor #(
        .CLK_FREQ    (CLK_FREQ),
        .T_HIGH_NOM  (T_HIGH_NOM),
        .T_PERIOD_NOM(T_PERIOD_NOM),
        .TOL         (TOL),
        .T_TIMEOUT   (T_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .blink_i     (blink_i),
        .high_cnt_o  (high_cnt_o),
        .period_cnt_o(period_cnt_o),
        .meas_valid_o(meas_valid_o),
        .high_ok_o   (high_ok_o),
        .period_ok_o (period_ok_o),
        .timeout_o   (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int h;
        int p;
        bit hok;
        bit pok;
        int cyc;
    } meas_t;

    int    errors = 0;
    int    checks = 0;
    int    cyc    = 0;
    meas_t got_q[$];
    meas_t exp_q[$];

    always @(posedge clk_i) cyc <= cyc + 1;

    // Every cycle with the strobe high is recorded, so a strobe that is
    // too long shows up as an extra entry.
    always @(posedge clk_i) begin
        #1;
        if (meas_valid_o !== 1'b0)
            got_q.push_back('{int'(high_cnt_o), int'(period_cnt_o), high_ok_o, period_ok_o, cyc});
    end

    // Reference: a period of h high and l low cycles measures h and h+l;
    // each is good when its distance from nominal is at most TOL.
    function automatic meas_t model(int h, int l);
        meas_t m;
        int    dh, dp;
        dh = h - T_HIGH_NOM;
        dp = (h + l) - T_PERIOD_NOM;
        if (dh < 0) dh = -dh;
        if (dp < 0) dp = -dp;
        m.h   = h;
        m.p   = h + l;
        m.hok = (dh <= TOL);
        m.pok = (dp <= TOL);
        m.cyc = 0;
        return m;
    endfunction

    task automatic do_reset();
        @(negedge clk_i);
        blink_i = 1'b0;
        rst_ni  = 1'b0;
        repeat (5) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (3) @(negedge clk_i);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic drive_pulse(input int h, input int l, output int t0);
        t0      = cyc;
        blink_i = 1'b1;
        repeat (h) @(negedge clk_i);
        blink_i = 1'b0;
        repeat (l) @(negedge clk_i);
    endtask

    task automatic final_rise();
        blink_i = 1'b1;
        repeat (6) @(negedge clk_i);
    endtask

    task automatic test_reset();
        int bad;
        bad     = 0;
        blink_i = 1'b0;
        rst_ni  = 1'b0;
        repeat (50) begin
            @(negedge clk_i);
            if ({high_cnt_o, period_cnt_o, meas_valid_o, high_ok_o, period_ok_o, timeout_o} !== '0)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_hold: nonzero output cycles=%0d required=0", bad);
        end
        rst_ni = 1'b1;
        repeat (20) @(negedge clk_i);
        checks++;
        if ({high_cnt_o, period_cnt_o, meas_valid_o, high_ok_o, period_ok_o, timeout_o} !== '0 ||
            got_q.size() != 0) begin
            errors++;
            $display("FAIL reset_release: high=%0d period=%0d tmo=%b strobes=%0d required all 0",
                     high_cnt_o, period_cnt_o, timeout_o, got_q.size());
        end
    endtask

    task automatic test_nominal();
        int t0, t1;
        do_reset();
        drive_pulse(100, 900, t0);
        drive_pulse(100, 900, t1);
        final_rise();
        exp_q.push_back(model(100, 900));
        exp_q.push_back(model(100, 900));
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL nominal_count: strobes=%0d required=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].h != exp_q[i].h || got_q[i].p != exp_q[i].p ||
                got_q[i].hok != exp_q[i].hok || got_q[i].pok != exp_q[i].pok) begin
                errors++;
                $display("FAIL nominal_%0d: got h=%0d p=%0d ok=%b%b required h=%0d p=%0d ok=%b%b", i,
                         got_q[i].h, got_q[i].p, got_q[i].hok, got_q[i].pok,
                         exp_q[i].h, exp_q[i].p, exp_q[i].hok, exp_q[i].pok);
            end
        end
        if (got_q.size() > 0) begin
            checks++;
            if (got_q[0].cyc != t1 + 3) begin
                errors++;
                $display("FAIL strobe_latency: cycle=%0d required=%0d", got_q[0].cyc, t1 + 3);
            end
        end
    endtask

    task automatic test_boundaries();
        int t0;
        do_reset();
        drive_pulse(102, 896, t0);
        drive_pulse(103, 900, t0);
        drive_pulse(98, 899, t0);
        final_rise();
        exp_q.push_back(model(102, 896));
        exp_q.push_back(model(103, 900));
        exp_q.push_back(model(98, 899));
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL bound_count: strobes=%0d required=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].h != exp_q[i].h || got_q[i].p != exp_q[i].p ||
                got_q[i].hok != exp_q[i].hok || got_q[i].pok != exp_q[i].pok) begin
                errors++;
                $display("FAIL bound_%0d: got h=%0d p=%0d ok=%b%b required h=%0d p=%0d ok=%b%b", i,
                         got_q[i].h, got_q[i].p, got_q[i].hok, got_q[i].pok,
                         exp_q[i].h, exp_q[i].p, exp_q[i].hok, exp_q[i].pok);
            end
        end
    endtask

    task automatic test_timeout();
        int t0;
        do_reset();
        drive_pulse(100, 900, t0);
        blink_i = 1'b1;
        repeat (100) @(negedge clk_i);
        blink_i = 1'b0;
        repeat (1890) @(negedge clk_i);
        checks++;
        if (timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: timeout=%b required=0", timeout_o);
        end
        repeat (20) @(negedge clk_i);
        checks++;
        if (timeout_o !== 1'b1) begin
            errors++;
            $display("FAIL timeout_set: timeout=%b required=1", timeout_o);
        end
        checks++;
        if (high_cnt_o !== 12'd100 || period_cnt_o !== 12'd1000 ||
            high_ok_o !== 1'b1 || period_ok_o !== 1'b1 || got_q.size() != 1) begin
            errors++;
            $display("FAIL timeout_hold: h=%0d p=%0d ok=%b%b strobes=%0d required h=100 p=1000 ok=11 strobes=1",
                     high_cnt_o, period_cnt_o, high_ok_o, period_ok_o, got_q.size());
        end
        exp_q.push_back(model(100, 900));
        // Rise after a timeout clears the flag but yields no result.
        blink_i = 1'b1;
        repeat (10) @(negedge clk_i);
        checks++;
        if (timeout_o !== 1'b0 || got_q.size() != 1) begin
            errors++;
            $display("FAIL timeout_clear: timeout=%b strobes=%0d required timeout=0 strobes=1",
                     timeout_o, got_q.size());
        end
        repeat (90) @(negedge clk_i);
        blink_i = 1'b0;
        repeat (900) @(negedge clk_i);
        // Period of exactly T_TIMEOUT: the rise wins over the timeout.
        drive_pulse(100, 1900, t0);
        final_rise();
        exp_q.push_back(model(100, 900));
        exp_q.push_back(model(100, 1900));
        checks++;
        if (got_q.size() != exp_q.size() || timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_after: strobes=%0d timeout=%b required strobes=%0d timeout=0",
                     got_q.size(), timeout_o, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].h != exp_q[i].h || got_q[i].p != exp_q[i].p ||
                got_q[i].hok != exp_q[i].hok || got_q[i].pok != exp_q[i].pok) begin
                errors++;
                $display("FAIL timeout_meas_%0d: got h=%0d p=%0d ok=%b%b required h=%0d p=%0d ok=%b%b", i,
                         got_q[i].h, got_q[i].p, got_q[i].hok, got_q[i].pok,
                         exp_q[i].h, exp_q[i].p, exp_q[i].hok, exp_q[i].pok);
            end
        end
    endtask

    task automatic test_reset_mid_high();
        int t0;
        do_reset();
        drive_pulse(100, 900, t0);
        blink_i = 1'b1;
        repeat (50) @(negedge clk_i);
        checks++;
        if (high_cnt_o !== 12'd100 || period_cnt_o !== 12'd1000) begin
            errors++;
            $display("FAIL midrst_pre: h=%0d p=%0d required h=100 p=1000", high_cnt_o, period_cnt_o);
        end
        @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({high_cnt_o, period_cnt_o, meas_valid_o, high_ok_o, period_ok_o, timeout_o} !== '0) begin
            errors++;
            $display("FAIL midrst_async: h=%0d p=%0d ok=%b%b tmo=%b required all 0",
                     high_cnt_o, period_cnt_o, high_ok_o, period_ok_o, timeout_o);
        end
        blink_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (3) @(negedge clk_i);
        got_q.delete();
        exp_q.delete();
        drive_pulse(101, 899, t0);
        checks++;
        if (got_q.size() != 0) begin
            errors++;
            $display("FAIL midrst_first_rise: strobes=%0d required=0", got_q.size());
        end
        drive_pulse(99, 902, t0);
        final_rise();
        exp_q.push_back(model(101, 899));
        exp_q.push_back(model(99, 902));
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL midrst_count: strobes=%0d required=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].h != exp_q[i].h || got_q[i].p != exp_q[i].p ||
                got_q[i].hok != exp_q[i].hok || got_q[i].pok != exp_q[i].pok) begin
                errors++;
                $display("FAIL midrst_meas_%0d: got h=%0d p=%0d ok=%b%b required h=%0d p=%0d ok=%b%b", i,
                         got_q[i].h, got_q[i].p, got_q[i].hok, got_q[i].pok,
                         exp_q[i].h, exp_q[i].p, exp_q[i].hok, exp_q[i].pok);
            end
        end
    endtask

    task automatic test_short_pulse();
        int t0;
        do_reset();
        drive_pulse(1, 999, t0);
        final_rise();
        checks++;
        if (got_q.size() != 1) begin
            errors++;
            $display("FAIL short_count: strobes=%0d required=1", got_q.size());
        end else begin
            exp_q.push_back(model(1, 999));
            checks++;
            if (got_q[0].h != exp_q[0].h || got_q[0].p != exp_q[0].p ||
                got_q[0].hok != exp_q[0].hok || got_q[0].pok != exp_q[0].pok) begin
                errors++;
                $display("FAIL short_meas: got h=%0d p=%0d ok=%b%b required h=%0d p=%0d ok=%b%b",
                         got_q[0].h, got_q[0].p, got_q[0].hok, got_q[0].pok,
                         exp_q[0].h, exp_q[0].p, exp_q[0].hok, exp_q[0].pok);
            end
        end
    endtask

    task automatic test_random();
        int t0, h, p;
        do_reset();
        for (int n = 0; n < 8; n++) begin
            h = ($urandom_range(0, 1) == 0) ? int'($urandom_range(95, 105)) : int'($urandom_range(1, 300));
            p = ($urandom_range(0, 1) == 0) ? int'($urandom_range(995, 1005)) : h + int'($urandom_range(1, 1500));
            exp_q.push_back(model(h, p - h));
            drive_pulse(h, p - h, t0);
        end
        final_rise();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand_count: strobes=%0d required=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].h != exp_q[i].h || got_q[i].p != exp_q[i].p ||
                got_q[i].hok != exp_q[i].hok || got_q[i].pok != exp_q[i].pok) begin
                errors++;
                $display("FAIL rand_%0d: got h=%0d p=%0d ok=%b%b required h=%0d p=%0d ok=%b%b", i,
                         got_q[i].h, got_q[i].p, got_q[i].hok, got_q[i].pok,
                         exp_q[i].h, exp_q[i].p, exp_q[i].hok, exp_q[i].pok);
            end
        end
        repeat (50) @(negedge clk_i);
        checks++;
        if (int'(high_cnt_o) != exp_q[7].h || int'(period_cnt_o) != exp_q[7].p ||
            high_ok_o !== exp_q[7].hok || period_ok_o !== exp_q[7].pok || meas_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rand_hold: h=%0d p=%0d ok=%b%b valid=%b required h=%0d p=%0d ok=%b%b valid=0",
                     high_cnt_o, period_cnt_o, high_ok_o, period_ok_o, meas_valid_o,
                     exp_q[7].h, exp_q[7].p, exp_q[7].hok, exp_q[7].pok);
        end
    endtask

    initial begin
        rst_ni  = 1'b0;
        blink_i = 1'b0;
        test_reset();
        test_nominal();
        test_boundaries();
        test_timeout();
        test_reset_mid_high();
        test_short_pulse();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
